// File: rtl/miss_return_scheduler.sv
// Purpose: holds outstanding cache misses in countdown entries and returns each address once its latency expires.
// Latency: request accepted at edge k with latency L (0 treated as 1) is returned on addr_response after edge k+L.
// Backpressure: req_ready drops when every entry is valid; one return per cycle, ties resolved by lowest entry index.
// Optional feature: define MISS_SCHED_DEDUP_EN to merge requests whose address matches an outstanding entry.
module miss_return_scheduler #(
    parameter int ENTRIES = 8,
    parameter int ADDR_W  = 27,
    parameter int LAT_W   = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [LAT_W-1:0]               req_latency,
    output logic                           req_ready,
    output logic [ADDR_W-1:0]              addr_response,
    output logic                           addr_response_valid,
    output logic [$clog2(ENTRIES+1)-1:0]   pending_count,
    output logic                           overflow
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = $clog2(ENTRIES + 1);

    // Entry state
    logic [ENTRIES-1:0]             valid_q, valid_d;
    logic [ENTRIES-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [ENTRIES-1:0][LAT_W-1:0]  cnt_q, cnt_d;

    // Output registers
    logic [ADDR_W-1:0] addr_response_q, addr_response_d;
    logic              addr_response_valid_q, addr_response_valid_d;
    logic [CNT_W-1:0]  pending_count_q, pending_count_d;
    logic              overflow_q, overflow_d;

    // Selection results
    logic              alloc_found;
    logic [IDX_W-1:0]  alloc_idx;
    logic              iss_found;
    logic [IDX_W-1:0]  iss_idx;
    logic              merge_hit;
    logic              accept;
    logic              do_alloc;

    // Pick the lowest free entry for allocation and the lowest expired entry for issue.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        iss_found   = 1'b0;
        iss_idx     = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!alloc_found && !valid_q[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
            if (!iss_found && valid_q[i] && (cnt_q[i] == '0)) begin
                iss_found = 1'b1;
                iss_idx   = IDX_W'(i);
            end
        end
    end

`ifdef MISS_SCHED_DEDUP_EN
    // Address match against outstanding entries; the entry leaving this edge cannot absorb a merge.
    always_comb begin
        merge_hit = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (addr_q[i] == req_addr) &&
                !(iss_found && (iss_idx == IDX_W'(i)))) begin
                merge_hit = 1'b1;
            end
        end
    end
`else
    // Without merging every request needs its own entry.
    always_comb begin
        merge_hit = 1'b0;
    end
`endif

    // Handshake: ready depends only on current entry state (and the address when merging).
    always_comb begin
        req_ready = alloc_found || merge_hit;
        accept    = req_valid && req_ready;
        do_alloc  = accept && !merge_hit;
    end

    // Next entry state: countdown, free the issued entry, write the new request.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - LAT_W'(1);
            end
        end
        if (iss_found) begin
            valid_d[iss_idx] = 1'b0;
        end
        // A freshly written entry is always a previously free one, so it never
        // collides with the issued entry and its count is not decremented here.
        if (do_alloc) begin
            valid_d[alloc_idx] = 1'b1;
            addr_d[alloc_idx]  = req_addr;
            cnt_d[alloc_idx]   = (req_latency == '0) ? '0 : (req_latency - LAT_W'(1));
        end
    end

    // Next output state: response pulse, held address, occupancy, sticky overflow.
    always_comb begin
        addr_response_valid_d = iss_found;
        addr_response_d       = iss_found ? addr_q[iss_idx] : addr_response_q;
        overflow_d            = overflow_q || (req_valid && !req_ready);
        pending_count_d       = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            pending_count_d = pending_count_d + CNT_W'(valid_d[i]);
        end
    end

    // State registers with synchronous reset; reset discards all in-flight misses.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q               <= '0;
            addr_q                <= '0;
            cnt_q                 <= '0;
            addr_response_q       <= '0;
            addr_response_valid_q <= 1'b0;
            pending_count_q       <= '0;
            overflow_q            <= 1'b0;
        end else begin
            valid_q               <= valid_d;
            addr_q                <= addr_d;
            cnt_q                 <= cnt_d;
            addr_response_q       <= addr_response_d;
            addr_response_valid_q <= addr_response_valid_d;
            pending_count_q       <= pending_count_d;
            overflow_q            <= overflow_d;
        end
    end

    assign addr_response       = addr_response_q;
    assign addr_response_valid = addr_response_valid_q;
    assign pending_count       = pending_count_q;
    assign overflow            = overflow_q;

endmodule

// File: tb/tb_miss_return_scheduler.sv
// Purpose: directed self-checking bench for miss_return_scheduler.
// Latency: drives inputs and samples outputs 1ns after each rising edge.
// Backpressure: holds a blocked request until the scheduler accepts it.
module tb_miss_return_scheduler;

    localparam int ENTRIES = 8;
    localparam int ADDR_W  = 27;
    localparam int LAT_W   = 5;
    localparam int CNT_W   = $clog2(ENTRIES + 1);

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic [LAT_W-1:0]  req_latency;
    logic              req_ready;
    logic [ADDR_W-1:0] addr_response;
    logic              addr_response_valid;
    logic [CNT_W-1:0]  pending_count;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    miss_return_scheduler #(
        .ENTRIES(ENTRIES),
        .ADDR_W (ADDR_W),
        .LAT_W  (LAT_W)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_addr           (req_addr),
        .req_latency        (req_latency),
        .req_ready          (req_ready),
        .addr_response      (addr_response),
        .addr_response_valid(addr_response_valid),
        .pending_count      (pending_count),
        .overflow           (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [ADDR_W-1:0] a, input logic [LAT_W-1:0] l);
        req_valid   = 1'b1;
        req_addr    = a;
        req_latency = l;
    endtask

    task automatic idle();
        req_valid   = 1'b0;
        req_addr    = '0;
        req_latency = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        int first_j;
        int peak;
        int bad_addr;

        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_vld",     32'(addr_response_valid), 32'd0);
        chk("rst_addr",    32'(addr_response),       32'd0);
        chk("rst_pending", 32'(pending_count),       32'd0);
        chk("rst_ovf",     32'(overflow),            32'd0);
        chk("rst_ready",   32'(req_ready),           32'd1);

        // Single request, latency 3: returns after edge k+3
        send(27'h05, 5'd3);
        tick();                                  // edge k
        idle();
        chk("l3_pend_k",   32'(pending_count),       32'd1);
        chk("l3_vld_k",    32'(addr_response_valid), 32'd0);
        tick();                                  // k+1
        chk("l3_vld_k1",   32'(addr_response_valid), 32'd0);
        tick();                                  // k+2
        chk("l3_vld_k2",   32'(addr_response_valid), 32'd0);
        tick();                                  // k+3
        chk("l3_vld_k3",   32'(addr_response_valid), 32'd1);
        chk("l3_addr_k3",  32'(addr_response),       32'h05);
        chk("l3_pend_k3",  32'(pending_count),       32'd0);
        tick();                                  // k+4
        chk("l3_vld_k4",   32'(addr_response_valid), 32'd0);
        chk("l3_hold_k4",  32'(addr_response),       32'h05);

        // Latency 0 and latency 1 each return one edge after accept
        send(27'h06, 5'd0);
        tick();
        idle();
        chk("l0_vld_k",    32'(addr_response_valid), 32'd0);
        chk("l0_pend_k",   32'(pending_count),       32'd1);
        tick();
        chk("l0_vld_k1",   32'(addr_response_valid), 32'd1);
        chk("l0_addr_k1",  32'(addr_response),       32'h06);
        send(27'h07, 5'd1);
        tick();
        idle();
        chk("l1_vld_k",    32'(addr_response_valid), 32'd0);
        tick();
        chk("l1_vld_k1",   32'(addr_response_valid), 32'd1);
        chk("l1_addr_k1",  32'(addr_response),       32'h07);

        // Three entries expire together and drain in index order
        send(27'h10, 5'd3);
        tick();
        send(27'h11, 5'd2);
        tick();
        send(27'h12, 5'd1);
        tick();
        idle();
        chk("ord_pend3",   32'(pending_count),       32'd3);
        tick();
        chk("ord_vld0",    32'(addr_response_valid), 32'd1);
        chk("ord_addr0",   32'(addr_response),       32'h10);
        tick();
        chk("ord_vld1",    32'(addr_response_valid), 32'd1);
        chk("ord_addr1",   32'(addr_response),       32'h11);
        tick();
        chk("ord_vld2",    32'(addr_response_valid), 32'd1);
        chk("ord_addr2",   32'(addr_response),       32'h12);
        tick();
        chk("ord_vld_end", 32'(addr_response_valid), 32'd0);
        chk("ord_pend0",   32'(pending_count),       32'd0);

        // Fill all entries with latency 31, then hold a ninth request
        for (int i = 0; i < ENTRIES; i++) begin
            send(27'h100 + 27'(i), 5'd31);
            tick();                              // edges e1 .. e1+7
        end
        send(27'h1FF, 5'd31);
        chk("full_pend",   32'(pending_count),       32'd8);
        chk("full_ready",  32'(req_ready),           32'd0);
        chk("full_ovf0",   32'(overflow),            32'd0);
        tick();                                  // e1+8
        chk("full_ovf1",   32'(overflow),            32'd1);
        seen = 0;
        for (int i = 0; i < 22; i++) begin       // e1+9 .. e1+30
            tick();
            if (addr_response_valid) seen++;
        end
        chk("full_no_early", 32'(seen),              32'd0);
        tick();                                  // e1+31: first return
        chk("full_ret_vld",  32'(addr_response_valid), 32'd1);
        chk("full_ret_addr", 32'(addr_response),       32'h100);
        chk("full_ready_ret", 32'(req_ready),          32'd1);
        tick();                                  // e1+32: ninth accepted
        idle();
        chk("ninth_pend",  32'(pending_count),       32'd7);
        chk("ninth_addr1", 32'(addr_response),       32'h101);
        bad_addr = 0;
        for (int i = 2; i < ENTRIES; i++) begin  // e1+33 .. e1+38
            tick();
            if (!addr_response_valid || addr_response != 27'h100 + 27'(i)) bad_addr++;
        end
        chk("drain_order", 32'(bad_addr),            32'd0);
        chk("drain_pend",  32'(pending_count),       32'd1);
        seen = 0;
        for (int i = 0; i < 24; i++) begin       // e1+39 .. e1+62
            tick();
            if (addr_response_valid) seen++;
        end
        chk("ninth_no_early", 32'(seen),             32'd0);
        tick();                                  // e1+63
        chk("ninth_vld",   32'(addr_response_valid), 32'd1);
        chk("ninth_addr",  32'(addr_response),       32'h1FF);
        chk("ninth_pend0", 32'(pending_count),       32'd0);
        chk("ovf_sticky",  32'(overflow),            32'd1);

        // Reset while four misses are outstanding
        for (int i = 0; i < 4; i++) begin
            send(27'h30 + 27'(i), 5'd10);
            tick();
        end
        idle();
        chk("prerst_pend", 32'(pending_count),       32'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_pend",   32'(pending_count),       32'd0);
        chk("mrst_ovf",    32'(overflow),            32'd0);
        chk("mrst_addr",   32'(addr_response),       32'd0);
        chk("mrst_ready",  32'(req_ready),           32'd1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (addr_response_valid) seen++;
        end
        chk("mrst_no_resp", 32'(seen),               32'd0);

        // Same address twice: merged with dedup, separate entries without
        send(27'h20, 5'd5);
        tick();                                  // edge k
        idle();
        seen     = 0;
        first_j  = 0;
        peak     = int'(pending_count);
        bad_addr = 0;
        for (int j = 1; j <= 10; j++) begin
            if (j == 2) send(27'h20, 5'd2);
            tick();                              // edge k+j
            if (j == 2) idle();
            if (int'(pending_count) > peak) peak = int'(pending_count);
            if (addr_response_valid) begin
                if (seen == 0) first_j = j;
                seen++;
                if (addr_response != 27'h20) bad_addr++;
            end
        end
        chk("dup_addr",    32'(bad_addr),            32'd0);
`ifdef MISS_SCHED_DEDUP_EN
        chk("dup_count",   32'(seen),                32'd1);
        chk("dup_first",   32'(first_j),             32'd5);
        chk("dup_peak",    32'(peak),                32'd1);
`else
        chk("dup_count",   32'(seen),                32'd2);
        chk("dup_first",   32'(first_j),             32'd4);
        chk("dup_peak",    32'(peak),                32'd2);
`endif
        chk("dup_pend_end", 32'(pending_count),      32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
